// File: rtl/wb_vga_timing_ctrl_pkg.sv
// Shared register map, bit positions and default 640x480@60 timing for the
// Wishbone VGA timing controller.
package vga_pkg;

  localparam int VGA_CNT_W = 12;

  localparam logic [3:0] OFF_CTRL      = 4'd0;
  localparam logic [3:0] OFF_STATUS    = 4'd1;
  localparam logic [3:0] OFF_H_ACT     = 4'd2;
  localparam logic [3:0] OFF_H_FP      = 4'd3;
  localparam logic [3:0] OFF_H_SW      = 4'd4;
  localparam logic [3:0] OFF_H_BP      = 4'd5;
  localparam logic [3:0] OFF_V_ACT     = 4'd6;
  localparam logic [3:0] OFF_V_FP      = 4'd7;
  localparam logic [3:0] OFF_V_SW      = 4'd8;
  localparam logic [3:0] OFF_V_BP      = 4'd9;
  localparam logic [3:0] OFF_FRAME_CNT = 4'd10;

  localparam int CTRL_EN        = 0;
  localparam int CTRL_H_POL     = 1;
  localparam int CTRL_V_POL     = 2;
  localparam int CTRL_IRQ_EN    = 3;
  localparam int STAT_VBLANK    = 0;
  localparam int STAT_IRQ_PEND  = 1;

  localparam int H_ACT_D = 640;
  localparam int H_FP_D  = 16;
  localparam int H_SW_D  = 96;
  localparam int H_BP_D  = 48;
  localparam int V_ACT_D = 480;
  localparam int V_FP_D  = 10;
  localparam int V_SW_D  = 2;
  localparam int V_BP_D  = 33;

  typedef struct packed {
    logic [VGA_CNT_W-1:0] h_act;
    logic [VGA_CNT_W-1:0] h_fp;
    logic [VGA_CNT_W-1:0] h_sw;
    logic [VGA_CNT_W-1:0] h_bp;
    logic [VGA_CNT_W-1:0] v_act;
    logic [VGA_CNT_W-1:0] v_fp;
    logic [VGA_CNT_W-1:0] v_sw;
    logic [VGA_CNT_W-1:0] v_bp;
  } vga_timing_t;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    for (int b = 0; b < 4; b++)
      res[b*8 +: 8] = sel[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
    return res;
  endfunction

endpackage

// File: rtl/wb_vga_timing_ctrl_if.sv
// Wishbone classic slave bus bundle for the VGA timing controller.
interface wb_vga_timing_ctrl_if #(parameter int DAT_W = 32);
  logic               cyc;
  logic               stb;
  logic               we;
  logic [DAT_W/8-1:0] sel;
  logic [31:0]        adr;
  logic [DAT_W-1:0]   dat;
  logic [DAT_W-1:0]   dout;
  logic               ack;

  modport master (output cyc, stb, we, sel, adr, dat, input dout, ack);
  modport slave  (input cyc, stb, we, sel, adr, dat, output dout, ack);
endinterface

// File: rtl/wb_vga_timing_ctrl_timing_gen.sv
// Raster h/v counters, region decode and registered video outputs driven by
// the live timing set; flags frame wrap and vblank entry to the register file.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int         CNT_W   = VGA_CNT_W,
  parameter logic [1:0] POL_DEF = 2'b00
) (
  input  logic              clk,
  input  logic              rst,
  input  vga_timing_t       tim,
  input  logic              en,
  input  logic              h_pol,
  input  logic              v_pol,
  output logic              h_sync,
  output logic              v_sync,
  output logic              n_blank,
  output logic              n_sync,
  output logic              display_enable,
  output logic [CNT_W-1:0]  row,
  output logic [CNT_W-1:0]  column,
  output logic              frame_wrap,
  output logic              vblank_start,
  output logic              in_vblank
);

  localparam int TW = CNT_W + 2;

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic [TW-1:0]    h_tot, v_tot, h_cnt_x, v_cnt_x;
  logic [TW-1:0]    hs_beg, hs_end, vs_beg, vs_end;
  logic             h_last, v_last, de, hs_act, vs_act;

  always_comb begin
    h_tot   = TW'(tim.h_act) + TW'(tim.h_fp) + TW'(tim.h_sw) + TW'(tim.h_bp);
    v_tot   = TW'(tim.v_act) + TW'(tim.v_fp) + TW'(tim.v_sw) + TW'(tim.v_bp);
    h_cnt_x = TW'(h_cnt);
    v_cnt_x = TW'(v_cnt);
    hs_beg  = TW'(tim.h_act) + TW'(tim.h_fp);
    hs_end  = hs_beg + TW'(tim.h_sw);
    vs_beg  = TW'(tim.v_act) + TW'(tim.v_fp);
    vs_end  = vs_beg + TW'(tim.v_sw);
    // a zero total never matches, so that counter simply stays at 0
    h_last  = (h_tot != '0) && (h_cnt_x == h_tot - TW'(1));
    v_last  = (v_tot != '0) && (v_cnt_x == v_tot - TW'(1));
    hs_act  = (h_cnt_x >= hs_beg) && (h_cnt_x < hs_end);
    vs_act  = (v_cnt_x >= vs_beg) && (v_cnt_x < vs_end);
    de      = (h_cnt < tim.h_act) && (v_cnt < tim.v_act);
    frame_wrap   = en && h_last && v_last;
    vblank_start = en && h_last && !v_last && (v_cnt_x + TW'(1) == TW'(tim.v_act));
    in_vblank    = (v_cnt >= tim.v_act);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!en) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= (v_last || v_tot == '0) ? '0 : v_cnt + 1'b1;
    end else if (h_tot != '0) begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_sync         <= ~POL_DEF[0];
      v_sync         <= ~POL_DEF[1];
      display_enable <= 1'b0;
      n_blank        <= 1'b0;
      n_sync         <= 1'b1;
      row            <= '0;
      column         <= '0;
    end else if (!en) begin
      h_sync         <= ~h_pol;
      v_sync         <= ~v_pol;
      display_enable <= 1'b0;
      n_blank        <= 1'b0;
      n_sync         <= 1'b1;
      row            <= '0;
      column         <= '0;
    end else begin
      h_sync         <= hs_act ? h_pol : ~h_pol;
      v_sync         <= vs_act ? v_pol : ~v_pol;
      display_enable <= de;
      n_blank        <= de;
      n_sync         <= ~(hs_act | vs_act);
      row            <= v_cnt;
      column         <= h_cnt;
    end
  end

endmodule

// File: rtl/wb_vga_timing_ctrl.sv
// Wishbone-programmable VGA timing controller: register file, frame-boundary
// shadow copy of the timing set, frame counter and vblank interrupt.
module wb_vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int         CNT_W     = VGA_CNT_W,
  parameter int         DAT_W     = 32,
  parameter int         H_ACT_DEF = H_ACT_D,
  parameter int         H_FP_DEF  = H_FP_D,
  parameter int         H_SW_DEF  = H_SW_D,
  parameter int         H_BP_DEF  = H_BP_D,
  parameter int         V_ACT_DEF = V_ACT_D,
  parameter int         V_FP_DEF  = V_FP_D,
  parameter int         V_SW_DEF  = V_SW_D,
  parameter int         V_BP_DEF  = V_BP_D,
  parameter logic [1:0] POL_DEF   = 2'b00,
  parameter logic       EN_DEF    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  wb_vga_timing_ctrl_if.slave   bus,
  output logic                  h_sync,
  output logic                  v_sync,
  output logic                  n_blank,
  output logic                  n_sync,
  output logic                  display_enable,
  output logic [CNT_W-1:0]      row,
  output logic [CNT_W-1:0]      column,
  output logic                  irq
);

  localparam vga_timing_t TIM_DEF = '{
    h_act: VGA_CNT_W'(H_ACT_DEF), h_fp: VGA_CNT_W'(H_FP_DEF),
    h_sw:  VGA_CNT_W'(H_SW_DEF),  h_bp: VGA_CNT_W'(H_BP_DEF),
    v_act: VGA_CNT_W'(V_ACT_DEF), v_fp: VGA_CNT_W'(V_FP_DEF),
    v_sw:  VGA_CNT_W'(V_SW_DEF),  v_bp: VGA_CNT_W'(V_BP_DEF)};

  vga_timing_t      prog, live;
  logic             enable, h_pol, v_pol, irq_en, irq_pend;
  logic [31:0]      frame_cnt;
  logic             frame_wrap, vblank_start, in_vblank;
  logic             req, wr;
  logic [3:0]       off;
  logic [31:0]      wdat;
  logic [3:0]       wsel;
  logic [DAT_W-1:0] rdata;
  logic             unused_adr;

  assign req        = bus.cyc & bus.stb & ~bus.ack;
  assign wr         = req & bus.we;
  assign off        = bus.adr[5:2];
  assign wdat       = 32'(bus.dat);
  assign wsel       = 4'(bus.sel);
  assign unused_adr = ^{bus.adr[31:6], bus.adr[1:0]};

  always_comb begin
    rdata = '0;
    case (off)
      OFF_CTRL:      rdata = DAT_W'({irq_en, v_pol, h_pol, enable});
      OFF_STATUS:    rdata = DAT_W'({irq_pend, in_vblank});
      OFF_H_ACT:     rdata = DAT_W'(prog.h_act);
      OFF_H_FP:      rdata = DAT_W'(prog.h_fp);
      OFF_H_SW:      rdata = DAT_W'(prog.h_sw);
      OFF_H_BP:      rdata = DAT_W'(prog.h_bp);
      OFF_V_ACT:     rdata = DAT_W'(prog.v_act);
      OFF_V_FP:      rdata = DAT_W'(prog.v_fp);
      OFF_V_SW:      rdata = DAT_W'(prog.v_sw);
      OFF_V_BP:      rdata = DAT_W'(prog.v_bp);
      OFF_FRAME_CNT: rdata = DAT_W'(frame_cnt);
      default:       rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.ack  <= 1'b0;
      bus.dout <= '0;
      enable   <= EN_DEF;
      h_pol    <= POL_DEF[0];
      v_pol    <= POL_DEF[1];
      irq_en   <= 1'b0;
      prog     <= TIM_DEF;
    end else begin
      bus.ack  <= req;
      bus.dout <= (req && !bus.we) ? rdata : '0;
      if (wr) begin
        case (off)
          OFF_CTRL:
            if (wsel[0]) begin
              enable <= wdat[CTRL_EN];
              h_pol  <= wdat[CTRL_H_POL];
              v_pol  <= wdat[CTRL_V_POL];
              irq_en <= wdat[CTRL_IRQ_EN];
            end
          OFF_H_ACT: prog.h_act <= VGA_CNT_W'(byte_merge(32'(prog.h_act), wdat, wsel));
          OFF_H_FP:  prog.h_fp  <= VGA_CNT_W'(byte_merge(32'(prog.h_fp),  wdat, wsel));
          OFF_H_SW:  prog.h_sw  <= VGA_CNT_W'(byte_merge(32'(prog.h_sw),  wdat, wsel));
          OFF_H_BP:  prog.h_bp  <= VGA_CNT_W'(byte_merge(32'(prog.h_bp),  wdat, wsel));
          OFF_V_ACT: prog.v_act <= VGA_CNT_W'(byte_merge(32'(prog.v_act), wdat, wsel));
          OFF_V_FP:  prog.v_fp  <= VGA_CNT_W'(byte_merge(32'(prog.v_fp),  wdat, wsel));
          OFF_V_SW:  prog.v_sw  <= VGA_CNT_W'(byte_merge(32'(prog.v_sw),  wdat, wsel));
          OFF_V_BP:  prog.v_bp  <= VGA_CNT_W'(byte_merge(32'(prog.v_bp),  wdat, wsel));
          default: ;
        endcase
      end
    end
  end

  // live timing only moves at a frame boundary (or freely while stopped)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      live      <= TIM_DEF;
      frame_cnt <= '0;
      irq_pend  <= 1'b0;
      irq       <= 1'b0;
    end else begin
      if (!enable || frame_wrap)
        live <= prog;
      if (frame_wrap)
        frame_cnt <= frame_cnt + 32'd1;
      if (vblank_start)
        irq_pend <= 1'b1;
      else if (wr && off == OFF_STATUS && wsel[0] && wdat[STAT_IRQ_PEND])
        irq_pend <= 1'b0;
      irq <= irq_pend & irq_en;
    end
  end

  vga_timing_gen #(.CNT_W(CNT_W), .POL_DEF(POL_DEF)) u_gen (
    .clk            (clk),
    .rst            (rst),
    .tim            (live),
    .en             (enable),
    .h_pol          (h_pol),
    .v_pol          (v_pol),
    .h_sync         (h_sync),
    .v_sync         (v_sync),
    .n_blank        (n_blank),
    .n_sync         (n_sync),
    .display_enable (display_enable),
    .row            (row),
    .column         (column),
    .frame_wrap     (frame_wrap),
    .vblank_start   (vblank_start),
    .in_vblank      (in_vblank)
  );

endmodule

// File: doc/wb_vga_timing_ctrl.md
Name: wb_vga_timing_ctrl

Overview:
Second-generation Wishbone VGA timing controller. All horizontal and vertical timing fields, sync polarities and enable are programmable over a Wishbone classic slave port. New timing values are applied only at frame boundaries, so a mode change never produces a torn frame. Adds a frame counter and a vblank interrupt. Sits in the user project wrapper on the wb_clk_i/wb_rst_i bus, and drives VGA DAC control pins and pixel coordinates to io_out.

Parameters:
CNT_W, 12, width of the h/v counters, the timing fields, and the row/column outputs
DAT_W, 32, Wishbone data width
H_ACT_DEF / H_FP_DEF / H_SW_DEF / H_BP_DEF, 640/16/96/48, reset horizontal timing in clocks
V_ACT_DEF / V_FP_DEF / V_SW_DEF / V_BP_DEF, 480/10/2/33, reset vertical timing in lines
POL_DEF, 2'b00, reset {v_pol,h_pol}; 1 = active-high sync
EN_DEF, 1, reset value of CTRL.enable

Ports:
clk  in  1  single clock for bus and pixel timing
rst  in  1  asynchronous, active-low reset
cyc  in  1  Wishbone cycle
stb  in  1  Wishbone strobe
we  in  1  Wishbone write enable
sel  in  DAT_W/8  byte selects
adr  in  32  byte address; only adr[5:2] decoded
dat  in  DAT_W  write data
dout  out  DAT_W  read data, valid with ack
ack  out  1  Wishbone acknowledge
h_sync  out  1  horizontal sync, polarity per CTRL
v_sync  out  1  vertical sync, polarity per CTRL
n_blank  out  1  low outside the active area
n_sync  out  1  low while either sync is active
display_enable  out  1  high inside the active area
row  out  CNT_W  current v counter
column  out  CNT_W  current h counter
irq  out  1  vblank interrupt, level

Behaviour:
- Register map (word offsets via adr[5:2]):
  - 0 CTRL {irq_en[3], v_pol[2], h_pol[1], enable[0]}
  - 1 STATUS {irq_pend[1] W1C, in_vblank[0] RO}
  - 2-5 H_ACT, H_FP, H_SW, H_BP
  - 6-9 V_ACT, V_FP, V_SW, V_BP
  - 10 FRAME_CNT, RO, 32 bit
  - Unmapped offsets: reads return 0, writes are ignored.
- Writes honour sel per byte. Timing fields keep bits [CNT_W-1:0]; upper bits read as 0.
- Bus handshake:
  - ack <= cyc & stb & ~ack, so ack is high for exactly one cycle, one clock after the request.
  - dout is registered in the same cycle as ack and is 0 when ack is low.
  - The write takes effect on the ack edge.
- Shadow timing: every bus write lands in the programmed set. The live set, used by the counters, is copied from the programmed set on the clock where h_cnt == H_TOT-1 and v_cnt == V_TOT-1, and on every clock while enable = 0. Reads return the programmed set.
- Totals: H_TOT = H_ACT+H_FP+H_SW+H_BP and V_TOT likewise, computed at CNT_W+2 bits. If a total is 0, that counter holds at 0.
- Counters:
  - h_cnt counts 0..H_TOT-1 and wraps.
  - v_cnt increments when h_cnt wraps, and wraps itself at V_TOT-1.
  - enable = 0 holds both counters at 0 and forces all outputs to their inactive levels.
- Region decode, with combinational hs_act / vs_act / de:
  - de = (h_cnt < H_ACT) & (v_cnt < V_ACT)
  - hs_act = H_ACT+H_FP <= h_cnt < H_ACT+H_FP+H_SW
  - vs_act uses the same form on v_cnt
  - A sync width of 0 produces no pulse.
- Outputs are registered, one clock latency from the counters:
  - h_sync = hs_act ? h_pol : ~h_pol (v_sync likewise with v_pol)
  - display_enable = n_blank = de
  - n_sync = ~(hs_act | vs_act)
  - column/row = h_cnt/v_cnt
- in_vblank = v_cnt >= V_ACT.
- irq_pend sets on the clock where v_cnt steps from V_ACT-1 to V_ACT. If a set and a W1C clear land on the same clock, the set wins. irq = irq_pend & irq_en.
- FRAME_CNT increments on every frame wrap and rolls over from 2^32-1 to 0.
- Reset values, asynchronously and including mid-frame:
  - counters 0, FRAME_CNT 0, irq_pend 0
  - registers at their *_DEF values
  - ack 0, dout 0, irq 0
  - display_enable 0, n_blank 0, n_sync 1
  - h_sync = ~POL_DEF[0], v_sync = ~POL_DEF[1]
  - row and column 0
- Counting resumes on the first clock after rst deasserts.

Decomposition:
- Package vga_pkg holds:
  - register offset constants
  - CTRL/STATUS bit indices
  - default 640x480@60 timing constants
  - a vga_timing_t struct of the 8 fields
- Sub-module vga_timing_gen takes the live vga_timing_t, enable and polarities. It holds the counters and the registered outputs, and emits frame_wrap and vblank_start pulses.
- The top level holds the Wishbone register file, the shadow copy, FRAME_CNT and irq logic.

Test Plan:
- Reset defaults: hold rst low, then release.
  - All outputs at their reset values; h_sync = 1.
  - First h_sync low at column 656; line length 800 clocks.
  - v_sync low for lines 490-491; frame = 525 lines.
- Bus read/write: write H_ACT = 0x123 with sel = 4'b0001, then read back.
  - Read returns 0x23 in byte 0 with the upper bytes unchanged, giving 0x223.
  - Each ack is exactly 1 cycle, 1 clock after stb.
  - Reading offset 12 returns 0.
- Shadow update: mid-frame, write a tiny mode H = 4/1/1/1, V = 2/1/1/1.
  - Old timing continues until the frame wrap.
  - Next frame: line = 7 clocks, frame = 5 lines, h_sync pulse at column 5.
- IRQ: set irq_en with the tiny mode.
  - irq rises one clock after v_cnt reaches 2.
  - W1C on STATUS clears it.
  - A W1C issued on the same clock as a vblank_start leaves irq_pend = 1.
- Polarity/enable/mid-frame reset:
  - h_pol = 1 gives a positive h_sync pulse.
  - enable = 0 gives row/column = 0 and display_enable = 0.
  - Asserting rst mid-line returns all outputs to reset values within the same cycle, without waiting for a clock edge.
- FRAME_CNT: preload via force to 0xFFFFFFFF, then complete one tiny frame.
  - Read returns 0.
